fp_exc_pipe: RTL and testbench
==============================

FP_EXC_PIPE -- requirements
Module: fp_exc_pipe

Interface
REQ-001 SHALL provide parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL provide parameter MAN_W, default 23, mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL provide parameter STICKY_EN, default 1, 1 = sticky flag register present, 0 = sticky outputs tied 0.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as listed in REQ-005 and REQ-006.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand set present.
REQ-008 in_ready  output  1  stage 1 can accept a transfer.
REQ-009 x  input  W  operand X, IEEE-style {sign, exp, man}.
REQ-010 y  input  W  operand Y.
REQ-011 sub  input  1  1 = X-Y (Y sign inverted), 0 = X+Y.
REQ-012 z_exp  input  EXP_W+1  unrounded result exponent from adder datapath, MSB = carry.
REQ-013 out_valid  output  1  stage 2 holds a result.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 special  output  1  result is fixed by an exception; use special_word instead of the datapath result.
REQ-016 special_word  output  W  forced result word.
REQ-017 x_is_inf, y_is_inf, x_is_nan, y_is_nan  output  1 each  per-transfer classification.
REQ-018 invalid, overflow  output  1 each  per-transfer exception flags.
REQ-019 flag_clr  input  1  clears sticky flags.
REQ-020 sticky_invalid, sticky_overflow  output  1 each  accumulated flags.

Function
REQ-021 Pipeline SHALL be 2 stages (S1 classify, S2 resolve); latency exactly 2 cycles from accepted input to out_valid with no stall.
REQ-022 Transfer SHALL occur on in_valid & in_ready (input) and out_valid & out_ready (output).
REQ-023 in_ready SHALL equal ~S1_valid | ~S2_valid | out_ready (each stage advances when its successor is empty or advancing).
REQ-024 Under stall (out_valid & ~out_ready) all S2 outputs SHALL hold stable; S1 SHALL hold if full.
REQ-025 S1 SHALL register: maxe = exp all ones, zman = mantissa all zeros, for X and Y; effective Y sign = y.sign ^ sub; z_exp.
REQ-026 inf = maxe & zman; nan = maxe & ~zman, per operand.
REQ-027 invalid SHALL be 1 iff either operand is NaN, or both are inf with differing X sign and effective Y sign.
REQ-028 overflow SHALL be 1 iff z_exp >= 2^EXP_W - 1 and neither operand is inf or NaN.
REQ-029 special_word priority: invalid -> canonical qNaN {0, all ones, 1, zeros}; else X inf -> {x.sign, all ones, zeros}; else Y inf -> {eff Y sign, all ones, zeros}; else overflow -> inf with X sign; else 0.
REQ-030 special SHALL equal invalid | x_is_inf | y_is_inf | overflow.
REQ-031 Sticky flags SHALL set on the cycle a flagged result transfers out (out_valid & out_ready), not while stalled.
REQ-032 flag_clr and a simultaneous set in the same cycle: the set SHALL win (flag = 1 next cycle).
REQ-033 Flag and word outputs SHALL be 0 whenever out_valid = 0.

Reset
REQ-034 On rst: S1_valid, S2_valid, out_valid, all flags, sticky flags, special_word = 0; in_ready = 1 the cycle after rst.
REQ-035 rst mid-operation SHALL discard in-flight transfers; no sticky update from a discarded transfer.
REQ-036 rst SHALL take priority over in_valid, out_ready and flag_clr in the same cycle.

Verification
REQ-037 x=0x7F800000, y=0x3F800000, sub=0, out_ready=1 -> 2 cycles later out_valid=1, x_is_inf=1, special_word=0x7F800000, invalid=0.
REQ-038 x=0x7F800000, y=0x7F800000, sub=1 -> invalid=1, special_word=0x7FC00000, sticky_invalid=1 next cycle.
REQ-039 x=0x7F7FFFFF, y=0x7F7FFFFF, z_exp=0x0FF -> overflow=1, special_word=0x7F800000; z_exp=0x0FE -> overflow=0, special=0.
REQ-040 3 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, output held stable, all 3 results delivered in order once out_ready=1.
REQ-041 flag_clr=1 in the cycle a NaN result (y=0x7FC00001) transfers out -> sticky_invalid=1 after; flag_clr alone next cycle -> 0.
REQ-042 rst asserted with both stages full -> out_valid=0 next cycle, sticky flags 0, no stale output after rst releases.

Source files
------------

// File: rtl/fp_exc_pipe.sv
// Two-stage floating-point add/sub exception resolver: S1 classifies operands,
// S2 holds the resolved exception flags and forced result word.
module fp_exc_pipe #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int STICKY_EN = 1,
  localparam int W        = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic             sub,
  input  logic [EXP_W:0]   z_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             special,
  output logic [W-1:0]     special_word,
  output logic             x_is_inf,
  output logic             y_is_inf,
  output logic             x_is_nan,
  output logic             y_is_nan,
  output logic             invalid,
  output logic             overflow,
  input  logic             flag_clr,
  output logic             sticky_invalid,
  output logic             sticky_overflow
);

  typedef struct packed {
    logic           xmaxe;
    logic           xzman;
    logic           ymaxe;
    logic           yzman;
    logic           xs;
    logic           ys;
    logic [EXP_W:0] zexp;
  } s1_t;

  typedef struct packed {
    logic         xinf;
    logic         yinf;
    logic         xnan;
    logic         ynan;
    logic         inv;
    logic         ovf;
    logic [W-1:0] word;
  } s2_t;

  localparam logic [EXP_W:0] OVF_TH = {1'b0, {EXP_W{1'b1}}};

  logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d, res;
  logic s1_adv, s2_adv, fire;

  assign s2_adv   = ~s2_vld_q | out_ready;
  assign s1_adv   = ~s1_vld_q | s2_adv;
  assign in_ready = s1_adv;
  assign fire     = s2_vld_q & out_ready;

  // Resolve from the classification registered in S1.
  always_comb begin
    res      = '0;
    res.xinf = s1_q.xmaxe &  s1_q.xzman;
    res.xnan = s1_q.xmaxe & ~s1_q.xzman;
    res.yinf = s1_q.ymaxe &  s1_q.yzman;
    res.ynan = s1_q.ymaxe & ~s1_q.yzman;
    res.inv  = res.xnan | res.ynan | (res.xinf & res.yinf & (s1_q.xs ^ s1_q.ys));
    res.ovf  = (s1_q.zexp >= OVF_TH) & ~(s1_q.xmaxe | s1_q.ymaxe);
    if (res.inv)
      res.word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (res.xinf)
      res.word = {s1_q.xs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (res.yinf)
      res.word = {s1_q.ys, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (res.ovf)
      res.word = {s1_q.xs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
    if (s1_adv) begin
      s1_vld_d   = in_valid;
      s1_d.xmaxe = &x[W-2:MAN_W];
      s1_d.xzman = ~|x[MAN_W-1:0];
      s1_d.ymaxe = &y[W-2:MAN_W];
      s1_d.yzman = ~|y[MAN_W-1:0];
      s1_d.xs    = x[W-1];
      s1_d.ys    = y[W-1] ^ sub;
      s1_d.zexp  = z_exp;
    end
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      s2_d     = res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  // Gate with valid so nothing stale leaks out of an empty stage.
  assign out_valid    = s2_vld_q;
  assign x_is_inf     = s2_vld_q & s2_q.xinf;
  assign y_is_inf     = s2_vld_q & s2_q.yinf;
  assign x_is_nan     = s2_vld_q & s2_q.xnan;
  assign y_is_nan     = s2_vld_q & s2_q.ynan;
  assign invalid      = s2_vld_q & s2_q.inv;
  assign overflow     = s2_vld_q & s2_q.ovf;
  assign special      = s2_vld_q & (s2_q.inv | s2_q.xinf | s2_q.yinf | s2_q.ovf);
  assign special_word = s2_vld_q ? s2_q.word : '0;

  generate
    if (STICKY_EN != 0) begin : g_sticky
      logic sinv_q, sinv_d, sovf_q, sovf_d;
      // A set in the same cycle as a clear wins.
      assign sinv_d = (sinv_q & ~flag_clr) | (fire & s2_q.inv);
      assign sovf_d = (sovf_q & ~flag_clr) | (fire & s2_q.ovf);
      always_ff @(posedge clk) begin
        if (rst) begin
          sinv_q <= 1'b0;
          sovf_q <= 1'b0;
        end else begin
          sinv_q <= sinv_d;
          sovf_q <= sovf_d;
        end
      end
      assign sticky_invalid  = sinv_q;
      assign sticky_overflow = sovf_q;
    end else begin : g_no_sticky
      assign sticky_invalid  = 1'b0;
      assign sticky_overflow = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_fp_exc_pipe.sv
// Scoreboard bench for fp_exc_pipe: stimulus pushes model results, a monitor
// compares outputs, in_ready and sticky flags every cycle.
module tb_fp_exc_pipe;

  logic        clk, rst, in_valid, in_ready, sub, out_valid, out_ready, flag_clr;
  logic [31:0] x, y, special_word;
  logic [8:0]  z_exp;
  logic        special, x_is_inf, y_is_inf, x_is_nan, y_is_nan, invalid, overflow;
  logic        sticky_invalid, sticky_overflow;

  fp_exc_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sub(sub), .z_exp(z_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .special(special), .special_word(special_word),
    .x_is_inf(x_is_inf), .y_is_inf(y_is_inf), .x_is_nan(x_is_nan), .y_is_nan(y_is_nan),
    .invalid(invalid), .overflow(overflow), .flag_clr(flag_clr),
    .sticky_invalid(sticky_invalid), .sticky_overflow(sticky_overflow)
  );

  typedef struct packed {
    logic        xi, yi, xn, yn, inv, ovf, sp;
    logic [31:0] w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: IEEE single-precision exception rules from the field values.
  function automatic exp_t model(input logic [31:0] a, b, input logic s, input logic [8:0] ze);
    exp_t r;
    logic bs;
    int   ea, eb;
    r  = '0;
    bs = b[31] ^ s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r.xi  = (ea == 255) && (a[22:0] == 23'd0);
    r.xn  = (ea == 255) && (a[22:0] != 23'd0);
    r.yi  = (eb == 255) && (b[22:0] == 23'd0);
    r.yn  = (eb == 255) && (b[22:0] != 23'd0);
    r.inv = r.xn || r.yn || (r.xi && r.yi && (a[31] != bs));
    r.ovf = (int'(ze) >= 255) && !(r.xi || r.yi || r.xn || r.yn);
    r.sp  = r.inv || r.xi || r.yi || r.ovf;
    if (r.inv)      r.w = 32'h7FC0_0000;
    else if (r.xi)  r.w = {a[31], 31'h7F80_0000};
    else if (r.yi)  r.w = {bs, 31'h7F80_0000};
    else if (r.ovf) r.w = {a[31], 31'h7F80_0000};
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 3))
      0:       e = 8'hFF;
      1:       e = 8'hFE;
      default: e = 8'($urandom);
    endcase
    m = ($urandom_range(0, 1) == 1) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  function automatic logic [8:0] rnd_zexp();
    case ($urandom_range(0, 3))
      0:       return 9'h0FF;
      1:       return 9'h0FE;
      default: return 9'($urandom);
    endcase
  endfunction

  // Called and returns at posedge+1; holds in_valid until accepted.
  task automatic send(input logic [31:0] xv, yv, input logic sb, input logic [8:0] ze);
    int n;
    n = 0;
    x = xv; y = yv; sub = sb; z_exp = ze; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready && !rst) begin
        q.push_back(model(xv, yv, sb, ze));
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 60) begin
        checks++; failures++;
        $display("FAIL accept_timeout x=%h y=%h in_ready=%b required 1", xv, yv, in_ready);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: sampled 2 time units after each falling edge.
  initial begin
    int   occ;
    logic si, so, fire, rdy_exp;
    exp_t a, e;
    occ = 0; si = 1'b0; so = 1'b0;
    @(posedge clk); @(posedge clk);
    forever begin
      @(negedge clk); #2;
      checks++;
      if (sticky_invalid !== si || sticky_overflow !== so) begin
        failures++;
        $display("FAIL sticky got inv=%b ovf=%b required inv=%b ovf=%b",
                 sticky_invalid, sticky_overflow, si, so);
      end
      rdy_exp = (occ < 2) || out_ready;
      checks++;
      if (in_ready !== rdy_exp) begin
        failures++;
        $display("FAIL in_ready got %b required %b (occ=%0d)", in_ready, rdy_exp, occ);
      end
      a = {x_is_inf, y_is_inf, x_is_nan, y_is_nan, invalid, overflow, special, special_word};
      checks++;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got out_valid=1 word=%h required out_valid=0", special_word);
        end else if (a !== q[0]) begin
          failures++;
          $display("FAIL result got %h required %h", a, q[0]);
        end
      end else if (out_valid !== 1'b0 || a !== '0) begin
        failures++;
        $display("FAIL idle_outputs got valid=%b %h required 0", out_valid, a);
      end
      fire = (out_valid === 1'b1) && out_ready && (q.size() > 0);
      if (rst) begin
        q.delete(); occ = 0; si = 1'b0; so = 1'b0;
      end else begin
        e = fire ? q.pop_front() : '0;
        si = (si && !flag_clr) || (fire && e.inv);
        so = (so && !flag_clr) || (fire && e.ovf);
        occ = occ + ((in_valid && rdy_exp) ? 1 : 0) - (fire ? 1 : 0);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    x = '0; y = '0; sub = 1'b0; z_exp = '0;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    // Latency: inf + 1.0 on an empty pipe.
    send(32'h7F80_0000, 32'h3F80_0000, 1'b0, 9'h000);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL latency_early got out_valid=%b required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL latency got out_valid=%b required 1", out_valid);
    end
    @(posedge clk); #1;
    cycles(1);

    // inf - inf, then overflow boundary.
    send(32'h7F80_0000, 32'h7F80_0000, 1'b1, 9'h000);
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 9'h0FF);
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 9'h0FE);
    send(32'hFF80_0000, 32'h7F80_0000, 1'b0, 9'h1FF);
    cycles(4);

    // Back-to-back under a 4-cycle stall.
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 9'h0FF);
        send(32'h7FC0_0001, 32'h0, 1'b0, 9'h000);
        send(32'h0, 32'hFF80_0000, 1'b1, 9'h000);
      end
      begin
        cycles(4);
        out_ready = 1'b1;
      end
    join
    cycles(4);

    // Clear coinciding with a NaN transfer: set wins; clear alone then clears.
    out_ready = 1'b0;
    send(32'h3F80_0000, 32'h7FC0_0001, 1'b0, 9'h000);
    cycles(2);
    out_ready = 1'b1; flag_clr = 1'b1;
    cycles(1);
    cycles(1);
    flag_clr = 1'b0;
    cycles(2);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(32'h7F80_0000, 32'h7FC0_0000, 1'b0, 9'h0FF);
    send(32'h1234_5678, 32'h7F80_0000, 1'b0, 9'h1FF);
    cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0; out_ready = 1'b1;
    cycles(4);

    // Randomized traffic with random backpressure and clears.
    fork
      begin
        repeat (200) begin
          send(rnd_op(), rnd_op(), 1'($urandom), rnd_zexp());
          if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
        end
      end
      begin
        repeat (600) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          flag_clr  = ($urandom_range(0, 15) == 0);
        end
      end
    join
    out_ready = 1'b1; flag_clr = 1'b0;
    cycles(8);

    checks++;
    if (q.size() != 0) begin
      failures++; $display("FAIL drain got %0d pending results required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
